// File: rtl/usart_frame_recv_if.sv
// Decoded-frame bundle from the UART frame receiver to its consumer.
// The receiver drives everything (master); the consumer only observes (slave).
interface usart_frame_recv_if;
  logic [23:0] D;
  logic [1:0]  Adress;
  logic [5:0]  Mod_SEL;
  logic        frame_vld;
  logic        frame_err;

  modport master (
    output D,
    output Adress,
    output Mod_SEL,
    output frame_vld,
    output frame_err
  );

  modport slave (
    input D,
    input Adress,
    input Mod_SEL,
    input frame_vld,
    input frame_err
  );
endinterface

// File: rtl/usart_frame_recv.sv
// 8N1 UART receiver that reassembles the 5-byte result frame
// {address, mode select, D[23:16], D[15:8], D[7:0]} and presents it in
// parallel with a one-cycle valid strobe. Malformed frames, bad stop bits
// and inter-byte timeouts produce a one-cycle error strobe instead.
module usart_frame_recv #(
  parameter logic [15:0] BPS_CNT     = 16'd434,
  parameter logic [15:0] TIMEOUT_CNT = 16'd13020
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               uart_rxd,
  usart_frame_recv_if.master frm
);

  localparam logic [15:0] HALF_LAST = (BPS_CNT >> 1) - 16'd1;
  localparam logic [15:0] FULL_LAST = BPS_CNT - 16'd1;
  localparam logic [15:0] GAP_LAST  = TIMEOUT_CNT - 16'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Line synchroniser and edge-detect history
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_s3;
  logic        w_start_edge;

  // Bit-level receiver
  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        w_half_hit;
  logic        w_full_hit;
  logic        w_cnt_run;
  logic        w_bit_sample;
  logic        w_byte_done;
  logic        w_stop_err;

  // Frame assembly
  logic [2:0]  r_idx;
  logic [15:0] r_gap_cnt;
  logic        w_timeout;
  logic [1:0]  r_adr_sh;
  logic [5:0]  r_mod_sh;
  logic [7:0]  r_d_hi_sh;
  logic [7:0]  r_d_mid_sh;
  logic [23:0] r_d;
  logic [1:0]  r_adr;
  logic [5:0]  r_mod;
  logic        r_frame_vld;
  logic        r_frame_err;

  assign w_start_edge = r_rx_s3 & ~r_rx_s2;
  assign w_half_hit   = (r_baud_cnt == HALF_LAST);
  assign w_full_hit   = (r_baud_cnt == FULL_LAST);
  assign w_timeout    = (r_idx != 3'd0) && (r_gap_cnt == GAP_LAST);

  // Bring the asynchronous line into the clock domain; idle level is high
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rxd;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  // Bit FSM state register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Bit FSM next-state: STOP returns to IDLE at mid-stop so a following start edge is not missed
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_edge) w_state_next = ST_START;
      ST_START: if (w_half_hit) w_state_next = r_rx_s2 ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_full_hit && (r_bit_cnt == 3'd7)) w_state_next = ST_STOP;
      ST_STOP:  if (w_full_hit) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Bit FSM outputs: counter run/clear, data sampling and byte-level strobes
  always_comb begin
    w_cnt_run    = 1'b0;
    w_bit_sample = 1'b0;
    w_byte_done  = 1'b0;
    w_stop_err   = 1'b0;
    case (r_state)
      ST_START: w_cnt_run = ~w_half_hit;
      ST_DATA: begin
        w_cnt_run    = ~w_full_hit;
        w_bit_sample = w_full_hit;
      end
      ST_STOP: begin
        w_cnt_run   = ~w_full_hit;
        w_byte_done = w_full_hit & r_rx_s2;
        w_stop_err  = w_full_hit & ~r_rx_s2;
      end
      default: ;
    endcase
  end

  // Baud counter, bit counter and LSB-first shift register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_baud_cnt <= 16'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
    end else begin
      r_baud_cnt <= w_cnt_run ? (r_baud_cnt + 16'd1) : 16'd0;
      if (r_state != ST_DATA) begin
        r_bit_cnt <= 3'd0;
      end else if (w_bit_sample) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_bit_sample) begin
        r_shift <= {r_rx_s2, r_shift[7:1]};
      end
    end
  end

  // Inter-byte gap timer: only runs while a frame is partially received and the line is idle
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_gap_cnt <= 16'd0;
    end else if ((r_idx == 3'd0) || w_start_edge || w_timeout) begin
      r_gap_cnt <= 16'd0;
    end else if (r_state == ST_IDLE) begin
      r_gap_cnt <= r_gap_cnt + 16'd1;
    end
  end

  // Frame assembly; the last byte goes straight from the shift register to D so valid lands one cycle after its stop sample
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_idx       <= 3'd0;
      r_adr_sh    <= 2'd0;
      r_mod_sh    <= 6'd0;
      r_d_hi_sh   <= 8'd0;
      r_d_mid_sh  <= 8'd0;
      r_d         <= 24'd0;
      r_adr       <= 2'd0;
      r_mod       <= 6'd0;
      r_frame_vld <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_vld <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_stop_err) begin
        r_frame_err <= 1'b1;
        r_idx       <= 3'd0;
      end else if (w_byte_done) begin
        case (r_idx)
          3'd0: begin
            if (r_shift[7:2] != 6'd0) begin
              r_frame_err <= 1'b1;
            end else begin
              r_adr_sh <= r_shift[1:0];
              r_idx    <= 3'd1;
            end
          end
          3'd1: begin
            if (r_shift[7:6] != 2'd0) begin
              r_frame_err <= 1'b1;
              r_idx       <= 3'd0;
            end else begin
              r_mod_sh <= r_shift[5:0];
              r_idx    <= 3'd2;
            end
          end
          3'd2: begin
            r_d_hi_sh <= r_shift;
            r_idx     <= 3'd3;
          end
          3'd3: begin
            r_d_mid_sh <= r_shift;
            r_idx      <= 3'd4;
          end
          3'd4: begin
            r_d         <= {r_d_hi_sh, r_d_mid_sh, r_shift};
            r_adr       <= r_adr_sh;
            r_mod       <= r_mod_sh;
            r_frame_vld <= 1'b1;
            r_idx       <= 3'd0;
          end
          default: r_idx <= 3'd0;
        endcase
      end else if (w_timeout) begin
        r_frame_err <= 1'b1;
        r_idx       <= 3'd0;
      end
    end
  end

  assign frm.D         = r_d;
  assign frm.Adress    = r_adr;
  assign frm.Mod_SEL   = r_mod;
  assign frm.frame_vld = r_frame_vld;
  assign frm.frame_err = r_frame_err;

endmodule

// File: tb/tb_usart_frame_recv.sv
// Scoreboard bench for usart_frame_recv: a byte-stream reference model pushes
// expected frame/error events, an independent monitor pops and compares them.
module tb_usart_frame_recv;

  localparam int BPS = 16;
  localparam int TMO = 480;
  localparam int VLD_LAT = 9 * BPS + 11;

  typedef struct {
    bit          is_err;
    logic [1:0]  adr;
    logic [5:0]  mod;
    logic [23:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic sys_rst;
  logic uart_rxd;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_start_cyc = 0;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0]  pend_q[$];
  logic [1:0]  lg_adr;
  logic [5:0]  lg_mod;
  logic [23:0] lg_d;

  usart_frame_recv_if ifc();

  usart_frame_recv #(
    .BPS_CNT     (16'd16),
    .TIMEOUT_CNT (16'd480)
  ) dut (
    .sys_clk  (clk),
    .sys_rst  (sys_rst),
    .uart_rxd (uart_rxd),
    .frm      (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (byte stream -> frame events) ----------
  function automatic void push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.adr = lg_adr; e.mod = lg_mod; e.d = lg_d;
    exp_q.push_back(e);
    pend_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    exp_t e;
    if (!stop_ok) begin
      push_err();
    end else if (pend_q.size() == 0 && b > 8'd3) begin
      push_err();
    end else if (pend_q.size() == 1 && b > 8'd63) begin
      push_err();
    end else begin
      pend_q.push_back(b);
      if (pend_q.size() == 5) begin
        lg_adr = pend_q[0][1:0];
        lg_mod = pend_q[1][5:0];
        lg_d   = {pend_q[2], pend_q[3], pend_q[4]};
        e.is_err = 1'b0;
        e.adr = lg_adr; e.mod = lg_mod; e.d = lg_d;
        exp_q.push_back(e);
        pend_q.delete();
      end
    end
  endfunction

  function automatic void model_long_idle();
    if (pend_q.size() != 0) push_err();
  endfunction

  // ---------------- stimulus helpers ----------------------------------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line_byte(input logic [7:0] b, input bit stop_ok);
    last_start_cyc = cyc;
    uart_rxd = 1'b0;
    wait_clks(BPS);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_clks(BPS);
    end
    uart_rxd = stop_ok;
    wait_clks(BPS);
    uart_rxd = 1'b1;
    if (!stop_ok) wait_clks(BPS);
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    line_byte(b, stop_ok);
  endtask

  task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4);
    send(b0, 1'b1); send(b1, 1'b1); send(b2, 1'b1); send(b3, 1'b1); send(b4, 1'b1);
  endtask

  task automatic long_idle();
    model_long_idle();
    wait_clks(TMO + 120);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // ---------------- monitor --------------------------------------------------
  always @(negedge clk) begin
    if (ifc.frame_vld === 1'b1 && ifc.frame_err === 1'b1) begin
      total++; bad++;
      $display("FAIL vld_err_overlap at cyc=%0d got both high want one", cyc);
    end else if (ifc.frame_vld === 1'b1 || ifc.frame_err === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d got vld=%0b err=%0b want none",
                 cyc, ifc.frame_vld, ifc.frame_err);
      end else begin
        mon_e = exp_q.pop_front();
        if (ifc.frame_err !== mon_e.is_err || ifc.Adress !== mon_e.adr ||
            ifc.Mod_SEL !== mon_e.mod || ifc.D !== mon_e.d) begin
          bad++;
          $display("FAIL event cyc=%0d got err=%0b adr=%h mod=%h d=%h want err=%0b adr=%h mod=%h d=%h",
                   cyc, ifc.frame_err, ifc.Adress, ifc.Mod_SEL, ifc.D,
                   mon_e.is_err, mon_e.adr, mon_e.mod, mon_e.d);
        end else begin
          $display("event %s adr=%h mod=%h d=%h cyc=%0d",
                   mon_e.is_err ? "err" : "vld", ifc.Adress, ifc.Mod_SEL, ifc.D, cyc);
        end
        if (!mon_e.is_err) begin
          total++;
          if (cyc - last_start_cyc != VLD_LAT) begin
            bad++;
            $display("FAIL vld_latency got=%0d want=%0d", cyc - last_start_cyc, VLD_LAT);
          end
        end
      end
    end
  end

  // ---------------- main sequence -------------------------------------------
  initial begin
    logic [7:0] b;
    bit         ok;
    int         g;

    lg_adr = '0; lg_mod = '0; lg_d = '0;
    sys_rst  = 1'b1;
    uart_rxd = 1'b1;
    wait_clks(3);
    chk("rst_D", {8'd0, ifc.D}, 32'd0);
    chk("rst_adr", {30'd0, ifc.Adress}, 32'd0);
    chk("rst_mod", {26'd0, ifc.Mod_SEL}, 32'd0);
    chk("rst_pulses", {30'd0, ifc.frame_vld, ifc.frame_err}, 32'd0);
    sys_rst = 1'b0;
    wait_clks(5);

    // Back-to-back good frame
    send5(8'h02, 8'h15, 8'hA5, 8'h5A, 8'h3C);
    wait_clks(BPS);
    chk("hold_D", {8'd0, ifc.D}, 32'h00A55A3C);

    // Two frames with a one-bit gap between them
    send5(8'h01, 8'h3F, 8'h00, 8'h00, 8'h01);
    wait_clks(BPS);
    send5(8'h03, 8'h00, 8'hFF, 8'hFF, 8'hFF);
    wait_clks(BPS);

    // Partial frame abandoned by timeout, then a good frame
    send(8'h02, 1'b1); send(8'h15, 1'b1); send(8'hA5, 1'b1);
    long_idle();
    send5(8'h01, 8'h01, 8'h12, 8'h34, 8'h56);
    wait_clks(BPS);

    // Header violation, then resync on the next bytes
    send(8'h82, 1'b1);
    send5(8'h01, 8'h02, 8'h11, 8'h22, 8'h33);
    wait_clks(BPS);

    // Bad stop bit on byte 2; outputs must keep the previous frame
    send(8'h01, 1'b1);
    send(8'h3F, 1'b0);
    wait_clks(BPS);
    chk("stoperr_hold_D", {8'd0, ifc.D}, 32'h00112233);

    // Short low glitch on idle line: ignored
    uart_rxd = 1'b0;
    wait_clks(4);
    uart_rxd = 1'b1;
    wait_clks(3 * BPS);

    // Reset in the middle of byte 3
    send(8'h02, 1'b1); send(8'h15, 1'b1);
    last_start_cyc = cyc;
    uart_rxd = 1'b0;
    wait_clks(BPS);
    b = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      uart_rxd = b[i];
      wait_clks(BPS);
    end
    uart_rxd = b[3];
    wait_clks(BPS / 2);
    sys_rst = 1'b1;
    wait_clks(1);
    sys_rst = 1'b0;
    uart_rxd = 1'b1;
    pend_q.delete();
    lg_adr = '0; lg_mod = '0; lg_d = '0;
    chk("midrst_D", {8'd0, ifc.D}, 32'd0);
    chk("midrst_adr", {30'd0, ifc.Adress}, 32'd0);
    chk("midrst_mod", {26'd0, ifc.Mod_SEL}, 32'd0);
    chk("midrst_pulses", {30'd0, ifc.frame_vld, ifc.frame_err}, 32'd0);
    chk("midrst_queue", exp_q.size(), 32'd0);
    wait_clks(2 * BPS);
    send5(8'h02, 8'h15, 8'hA5, 8'h5A, 8'h3C);
    wait_clks(BPS);

    // Randomised byte stream with occasional header/stop errors and gaps
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 5; k++) begin
        if (k == 0) begin
          b = 8'($urandom_range(0, 3));
          if ($urandom_range(0, 19) == 0) b = b | (8'h04 << $urandom_range(0, 5));
        end else if (k == 1) begin
          b = 8'($urandom_range(0, 63));
          if ($urandom_range(0, 19) == 0) b = b | (8'h40 << $urandom_range(0, 1));
        end else begin
          b = 8'($urandom_range(0, 255));
        end
        ok = ($urandom_range(0, 24) != 0);
        send(b, ok);
        g = $urandom_range(0, 19);
        if (g == 0) long_idle();
        else if (g <= 5) wait_clks($urandom_range(1, 40));
      end
    end
    long_idle();

    wait_clks(100);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usart_frame_recv.md
Name: usart_frame_recv

Overview:
- Downstream counterpart of the 5-byte USART result transmitter: deserialises 8N1 UART bytes from the line and reassembles the frame {address, mode select, D[23:16], D[15:8], D[7:0]}.
- Presents the decoded fields in parallel with a one-cycle valid strobe.
- Used on the receiving board (or in loopback test) to recover Adress/Mod_SEL/D exactly as the transmitter packed them.
- Rejects malformed frames and resynchronises on inter-byte timeout.

Parameters:
- BPS_CNT, 16'd434: sys_clk cycles per UART bit (50 MHz / 115200).
- TIMEOUT_CNT, 16'd13020: idle sys_clk cycles allowed between bytes inside a frame (3 byte times) before the partial frame is discarded.

Ports:
- sys_clk  input  1  system clock.
- sys_rst  input  1  synchronous reset, active-high.
- uart_rxd  input  1  asynchronous serial line, idle high.
- D  output  24  received data, bytes 3..5, MSB first.
- Adress  output  2  received address, byte 1 bits [1:0].
- Mod_SEL  output  6  received mode select, byte 2 bits [5:0].
- frame_vld  output  1  one-cycle pulse: D/Adress/Mod_SEL updated with a new good frame.
- frame_err  output  1  one-cycle pulse: partial or bad frame discarded.

Behaviour:
- Reset: sys_rst sampled high on a sys_clk edge sets the following.
  - D=0, Adress=0, Mod_SEL=0, frame_vld=0, frame_err=0.
  - Synchroniser flops=1, bit FSM=IDLE, byte index=0, all counters=0.
  - Reset mid-byte or mid-frame abandons everything with no error pulse.
- Input sync: uart_rxd passes through 2 flops (rx_s1, rx_s2), plus rx_s3 for edge detection. A start edge is rx_s3=1 and rx_s2=0.
- Bit FSM:
  - IDLE: on a start edge go to START and clear the baud counter.
  - START: at baud count BPS_CNT/2-1 sample rx_s2.
    - If 1, it is a glitch: return to IDLE with no error.
    - If 0, clear the counter and go to DATA.
  - DATA: at each baud count BPS_CNT-1 sample one bit into a shift register, LSB first, and clear the counter. After 8 bits go to STOP.
  - STOP: at count BPS_CNT-1 sample rx_s2.
    - 1 gives byte_done (internal, one cycle).
    - 0 gives a framing error.
    - Either way return to IDLE immediately, so the next start edge is caught within half a stop bit.
- Frame assembly, byte index 0..4, on byte_done:
  - idx0: check byte[7:2]==0, else error. Store byte[1:0].
  - idx1: check byte[7:6]==0, else error. Store byte[5:0].
  - idx2..4: store into a D shadow register, [23:16], [15:8], [7:0] respectively.
  - idx4 completing: on the next cycle copy the shadows to D/Adress/Mod_SEL, pulse frame_vld, and set index=0.
  - Outputs hold their values until the next good frame; they are never cleared by errors.
- Latency: frame_vld rises 1 cycle after the byte-5 stop-bit sample.
- Gap timer:
  - Counts while index!=0 and the bit FSM is in IDLE. Cleared on any start edge and whenever index==0.
  - Reaching TIMEOUT_CNT-1 pulses frame_err, sets index=0 and clears the timer.
- Errors (header violation, stop bit = 0, timeout):
  - frame_err pulses for exactly 1 cycle, the index returns to 0 and the shadows are discarded.
  - frame_vld is not asserted for that frame.
  - A stop-bit error on idx0 also pulses frame_err.
- Simultaneous events:
  - Timeout terminal count coinciding with a start edge: the timeout wins, and the new byte becomes idx0.
  - frame_vld and frame_err are never high in the same cycle.
- Width rules: the baud counter and gap timer are 16-bit and must not wrap in normal operation. BPS_CNT must be ≥ 4.

Test Plan:
- BPS_CNT=16, TIMEOUT_CNT=480. Send 8N1 bytes 02,15,A5,5A,3C back-to-back. Expect frame_vld for 1 cycle 1 clk after the 5th stop sample, with Adress=2'b10, Mod_SEL=6'h15, D=24'hA55A3C, and frame_err=0 throughout.
- Send 01,3F,00,00,01, then 03,00,FF,FF,FF with a 1-bit idle gap. Expect two frame_vld pulses: (1,3F,000001) then (3,00,FFFFFF).
- Send 02,15,A5, then idle 480+ clks, then 01,01,12,34,56. Expect a frame_err pulse at the timeout, then frame_vld with Adress=1, Mod_SEL=1, D=123456. Expect no frame_vld for the partial frame.
- Send first byte 0x82 (header violation) followed by 01,02,11,22,33. Expect frame_err after the 0x82 stop sample. Then 01 is idx0, and after bytes 01,02,11,22,33 expect one frame_vld with Adress=1, Mod_SEL=2, D=112233; the remaining bytes never reach idx4.
- Drive byte 2 with stop bit=0. Expect frame_err and outputs unchanged from the previous frame. A 4-clk low glitch (< BPS_CNT/2) on an idle line must produce no error and no byte.
- Assert sys_rst for 1 clk while byte 3 is mid-DATA. Expect all outputs 0 on the next edge, no pulses, and a subsequent full frame 02,15,A5,5A,3C decoded correctly.
